// File: rtl/idelay_eye_calib_if.sv
// Bring-up side <-> eye calibration controller bundle: training samples in,
// delay-block controls and calibration results out.
interface idelay_eye_calib_if #(
  parameter int unsigned WIDTH     = 1,
  parameter int unsigned TAP_WIDTH = 9
);
  logic                 start;
  logic [WIDTH-1:0]     sample_q1;
  logic [WIDTH-1:0]     sample_q2;
  logic [WIDTH-1:0]     pattern_q1;
  logic [WIDTH-1:0]     pattern_q2;
  logic                 delay_load;
  logic [TAP_WIDTH-1:0] delay_cnt_value;
  logic                 delay_en_vtc;
  logic                 busy;
  logic                 done;
  logic                 fail;
  logic [TAP_WIDTH-1:0] eye_start;
  logic [TAP_WIDTH-1:0] eye_end;
  logic [TAP_WIDTH-1:0] tap_value;

  modport master (
    output start, sample_q1, sample_q2, pattern_q1, pattern_q2,
    input  delay_load, delay_cnt_value, delay_en_vtc, busy, done, fail,
           eye_start, eye_end, tap_value
  );

  modport slave (
    input  start, sample_q1, sample_q2, pattern_q1, pattern_q2,
    output delay_load, delay_cnt_value, delay_en_vtc, busy, done, fail,
           eye_start, eye_end, tap_value
  );
endinterface

// File: rtl/idelay_eye_calib.sv
// Input-delay eye training: sweeps all taps, finds the longest contiguous
// passing window and loads its centre tap into the delay block.
module idelay_eye_calib #(
  parameter int unsigned WIDTH         = 1,
  parameter int unsigned TAP_WIDTH     = 9,
  parameter int unsigned MAX_TAP       = 511,
  parameter int unsigned VTC_WAIT      = 16,
  parameter int unsigned SETTLE_CYCLES = 8,
  parameter int unsigned SAMPLE_CYCLES = 16,
  parameter int unsigned MIN_EYE       = 4,
  parameter int unsigned DEFAULT_TAP   = 0
) (
  input  logic               clk,
  input  logic               rst,
  idelay_eye_calib_if.slave  bus
);

  localparam int unsigned LEN_W   = TAP_WIDTH + 1;
  localparam int unsigned CNT_MAX = (VTC_WAIT > SETTLE_CYCLES)
                                    ? ((VTC_WAIT > SAMPLE_CYCLES) ? VTC_WAIT : SAMPLE_CYCLES)
                                    : ((SETTLE_CYCLES > SAMPLE_CYCLES) ? SETTLE_CYCLES : SAMPLE_CYCLES);
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [3:0] S_IDLE       = 4'd0;
  localparam logic [3:0] S_VTC_OFF    = 4'd1;
  localparam logic [3:0] S_LOAD       = 4'd2;
  localparam logic [3:0] S_SETTLE     = 4'd3;
  localparam logic [3:0] S_SAMPLE     = 4'd4;
  localparam logic [3:0] S_NEXT       = 4'd5;
  localparam logic [3:0] S_APPLY      = 4'd6;
  localparam logic [3:0] S_APPLY_WAIT = 4'd7;
  localparam logic [3:0] S_FINISH     = 4'd8;

  logic [3:0]           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [TAP_WIDTH-1:0] tap_q, tap_d;
  logic                 tap_fail_q, tap_fail_d;
  logic                 run_open_q, run_open_d;
  logic [TAP_WIDTH-1:0] run_start_q, run_start_d;
  logic [TAP_WIDTH-1:0] best_start_q, best_start_d;
  logic [LEN_W-1:0]     best_len_q, best_len_d;

  logic                 load_q, load_d;
  logic [TAP_WIDTH-1:0] cnt_value_q, cnt_value_d;
  logic                 en_vtc_q, en_vtc_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 fail_q, fail_d;
  logic [TAP_WIDTH-1:0] eye_start_q, eye_start_d;
  logic [TAP_WIDTH-1:0] eye_end_q, eye_end_d;
  logic [TAP_WIDTH-1:0] tap_value_q, tap_value_d;

  logic                 mismatch_c;
  logic                 close_c;
  logic [TAP_WIDTH-1:0] run_lo_c;
  logic [TAP_WIDTH-1:0] run_hi_c;
  logic [LEN_W-1:0]     run_len_c;
  logic [TAP_WIDTH-1:0] centre_c;
  logic                 at_max_c;

  assign mismatch_c = |((bus.sample_q1 ^ bus.pattern_q1) | (bus.sample_q2 ^ bus.pattern_q2));
  assign at_max_c   = (tap_q == TAP_WIDTH'(MAX_TAP));

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      tap_q        <= '0;
      tap_fail_q   <= 1'b0;
      run_open_q   <= 1'b0;
      run_start_q  <= '0;
      best_start_q <= '0;
      best_len_q   <= '0;
      load_q       <= 1'b0;
      cnt_value_q  <= '0;
      en_vtc_q     <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      fail_q       <= 1'b0;
      eye_start_q  <= '0;
      eye_end_q    <= '0;
      tap_value_q  <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      tap_q        <= tap_d;
      tap_fail_q   <= tap_fail_d;
      run_open_q   <= run_open_d;
      run_start_q  <= run_start_d;
      best_start_q <= best_start_d;
      best_len_q   <= best_len_d;
      load_q       <= load_d;
      cnt_value_q  <= cnt_value_d;
      en_vtc_q     <= en_vtc_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      fail_q       <= fail_d;
      eye_start_q  <= eye_start_d;
      eye_end_q    <= eye_end_d;
      tap_value_q  <= tap_value_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    tap_d        = tap_q;
    tap_fail_d   = tap_fail_q;
    run_open_d   = run_open_q;
    run_start_d  = run_start_q;
    best_start_d = best_start_q;
    best_len_d   = best_len_q;
    load_d       = 1'b0;
    cnt_value_d  = cnt_value_q;
    en_vtc_d     = en_vtc_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    fail_d       = fail_q;
    eye_start_d  = eye_start_q;
    eye_end_d    = eye_end_q;
    tap_value_d  = tap_value_q;
    close_c      = 1'b0;
    run_lo_c     = run_open_q ? run_start_q : tap_q;
    run_hi_c     = tap_q;
    run_len_c    = '0;
    centre_c     = best_start_q + TAP_WIDTH'((best_len_q - LEN_W'(1)) >> 1);

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d      = S_VTC_OFF;
          busy_d       = 1'b1;
          en_vtc_d     = 1'b0;
          fail_d       = 1'b0;
          cnt_d        = '0;
          tap_d        = '0;
          run_open_d   = 1'b0;
          run_start_d  = '0;
          best_start_d = '0;
          best_len_d   = '0;
        end
      end

      S_VTC_OFF: begin
        if (cnt_q == CNT_W'(VTC_WAIT - 1)) begin
          state_d     = S_LOAD;
          cnt_d       = '0;
          load_d      = 1'b1;
          cnt_value_d = tap_q;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_LOAD: begin
        state_d = S_SETTLE;
        cnt_d   = '0;
      end

      S_SETTLE: begin
        if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
          state_d    = S_SAMPLE;
          cnt_d      = '0;
          tap_fail_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      // Every sample cycle counts, even after the first mismatch
      S_SAMPLE: begin
        tap_fail_d = tap_fail_q | mismatch_c;
        if (cnt_q == CNT_W'(SAMPLE_CYCLES - 1)) begin
          state_d = S_NEXT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_NEXT: begin
        if (!tap_fail_q) begin
          if (!run_open_q) begin
            run_open_d  = 1'b1;
            run_start_d = tap_q;
          end
          if (at_max_c) begin
            close_c = 1'b1;
          end
        end else if (run_open_q) begin
          close_c  = 1'b1;
          run_hi_c = tap_q - TAP_WIDTH'(1);
        end
        run_len_c = LEN_W'(run_hi_c) - LEN_W'(run_lo_c) + LEN_W'(1);
        // Strict compare keeps the earliest window on a tie
        if (close_c) begin
          run_open_d = 1'b0;
          if (run_len_c > best_len_q) begin
            best_len_d   = run_len_c;
            best_start_d = run_lo_c;
          end
        end
        if (at_max_c) begin
          state_d = S_APPLY;
        end else begin
          state_d     = S_LOAD;
          tap_d       = tap_q + TAP_WIDTH'(1);
          load_d      = 1'b1;
          cnt_value_d = tap_q + TAP_WIDTH'(1);
        end
      end

      S_APPLY: begin
        state_d = S_APPLY_WAIT;
        cnt_d   = '0;
        load_d  = 1'b1;
        if (best_len_q >= LEN_W'(MIN_EYE)) begin
          tap_value_d = centre_c;
          cnt_value_d = centre_c;
          eye_start_d = best_start_q;
          eye_end_d   = best_start_q + TAP_WIDTH'(best_len_q - LEN_W'(1));
          fail_d      = 1'b0;
        end else begin
          tap_value_d = TAP_WIDTH'(DEFAULT_TAP);
          cnt_value_d = TAP_WIDTH'(DEFAULT_TAP);
          eye_start_d = '0;
          eye_end_d   = '0;
          fail_d      = 1'b1;
        end
      end

      S_APPLY_WAIT: begin
        if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
          state_d  = S_FINISH;
          cnt_d    = '0;
          en_vtc_d = 1'b1;
          busy_d   = 1'b0;
          done_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_FINISH: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.delay_load      = load_q;
  assign bus.delay_cnt_value = cnt_value_q;
  assign bus.delay_en_vtc    = en_vtc_q;
  assign bus.busy            = busy_q;
  assign bus.done            = done_q;
  assign bus.fail            = fail_q;
  assign bus.eye_start       = eye_start_q;
  assign bus.eye_end         = eye_end_q;
  assign bus.tap_value       = tap_value_q;

endmodule

// File: tb/tb_idelay_eye_calib.sv
// Bench for idelay_eye_calib: a delay-block model corrupts captured data off
// the pass set; results are compared with a window-search reference model.
module tb_idelay_eye_calib;

  localparam int unsigned WIDTH         = 2;
  localparam int unsigned TAP_WIDTH     = 6;
  localparam int unsigned MAX_TAP       = 31;
  localparam int unsigned VTC_WAIT      = 4;
  localparam int unsigned SETTLE_CYCLES = 2;
  localparam int unsigned SAMPLE_CYCLES = 4;
  localparam int unsigned MIN_EYE       = 4;
  localparam int unsigned DEFAULT_TAP   = 7;
  localparam int          TIMEOUT       = 3000;

  logic clk;
  logic rst;

  idelay_eye_calib_if #(.WIDTH(WIDTH), .TAP_WIDTH(TAP_WIDTH)) bus ();

  idelay_eye_calib #(
    .WIDTH(WIDTH), .TAP_WIDTH(TAP_WIDTH), .MAX_TAP(MAX_TAP), .VTC_WAIT(VTC_WAIT),
    .SETTLE_CYCLES(SETTLE_CYCLES), .SAMPLE_CYCLES(SAMPLE_CYCLES),
    .MIN_EYE(MIN_EYE), .DEFAULT_TAP(DEFAULT_TAP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Delay-block model state and scenario controls
  logic [32:0] pass_mask = '0;
  int          glitch_tap = -1;
  int          cur_tap = 0;
  int          k = 0;

  // Run monitors
  int done_cnt  = 0;
  int load_cnt  = 0;
  int last_load = -1;
  int vtc_viol  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Longest contiguous run of set bits, earliest on ties
  function automatic void ref_model(input logic [32:0] pm, output int es, output int ee,
                                    output int tv, output int f);
    int best_s = 0;
    int best_l = 0;
    int t = 0;
    int s;
    while (t <= int'(MAX_TAP)) begin
      if (pm[t]) begin
        s = t;
        while (pm[t]) t++;
        if (t - s > best_l) begin
          best_l = t - s;
          best_s = s;
        end
      end else begin
        t++;
      end
    end
    if (best_l >= int'(MIN_EYE)) begin
      es = best_s; ee = best_s + best_l - 1; tv = best_s + (best_l - 1) / 2; f = 0;
    end else begin
      es = 0; ee = 0; tv = int'(DEFAULT_TAP); f = 1;
    end
  endfunction

  function automatic logic [32:0] range_mask(input int lo, input int hi);
    logic [32:0] m = '0;
    for (int i = lo; i <= hi; i++) m[i] = 1'b1;
    return m;
  endfunction

  // Delay block + IDDR model: latches the tap on load, corrupts q1 off the pass set
  initial begin
    logic seen_load;
    int   seen_val;
    logic [WIDTH-1:0] q2;
    bus.pattern_q1 = '0;
    bus.pattern_q2 = '0;
    bus.sample_q1  = '0;
    bus.sample_q2  = '0;
    forever begin
      @(negedge clk);
      seen_load = bus.delay_load;
      seen_val  = int'(bus.delay_cnt_value);
      @(posedge clk);
      #1;
      if (seen_load) begin
        cur_tap = seen_val;
        k = 0;
      end else begin
        k++;
      end
      bus.pattern_q1 = WIDTH'($urandom);
      bus.pattern_q2 = WIDTH'($urandom);
      bus.sample_q1  = pass_mask[cur_tap] ? bus.pattern_q1
                                          : bus.pattern_q1 ^ WIDTH'($urandom_range(1, 3));
      q2 = bus.pattern_q2;
      if (cur_tap == glitch_tap && k == int'(SETTLE_CYCLES) + 2) q2 = q2 ^ WIDTH'(2'b10);
      bus.sample_q2 = q2;
    end
  end

  // Output monitor
  initial begin
    forever begin
      @(negedge clk);
      if (bus.done) done_cnt++;
      if (bus.delay_load) begin
        load_cnt++;
        last_load = int'(bus.delay_cnt_value);
      end
      if ((bus.busy || bus.delay_load) && bus.delay_en_vtc) vtc_viol++;
    end
  end

  task automatic clear_monitors();
    done_cnt = 0; load_cnt = 0; last_load = -1; vtc_viol = 0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic run_cal(input string name, input logic [32:0] pm, input int gtap,
                         input bit repulse);
    int es, ee, tv, f;
    logic [32:0] eff;
    logic got_done = 1'b0;
    pass_mask  = pm;
    glitch_tap = gtap;
    eff = pm;
    if (gtap >= 0) eff[gtap] = 1'b0;
    ref_model(eff, es, ee, tv, f);
    clear_monitors();
    pulse_start();
    check({name, ".busy_after_start"}, 32'(bus.busy), 32'd1);
    for (int i = 0; i < TIMEOUT; i++) begin
      @(negedge clk);
      if (repulse && i == 100) bus.start = 1'b1;
      if (repulse && i == 101) bus.start = 1'b0;
      if (bus.done) begin
        got_done = 1'b1;
        break;
      end
    end
    check({name, ".done_seen"}, 32'(got_done), 32'd1);
    repeat (3) @(negedge clk);
    check({name, ".eye_start"}, 32'(bus.eye_start), 32'(es));
    check({name, ".eye_end"},   32'(bus.eye_end),   32'(ee));
    check({name, ".tap_value"}, 32'(bus.tap_value), 32'(tv));
    check({name, ".fail"},      32'(bus.fail),      32'(f));
    check({name, ".busy_idle"}, 32'(bus.busy),      32'd0);
    check({name, ".en_vtc"},    32'(bus.delay_en_vtc), 32'd1);
    check({name, ".done_cnt"},  32'(done_cnt),      32'd1);
    check({name, ".load_cnt"},  32'(load_cnt),      32'(MAX_TAP + 2));
    check({name, ".last_load"}, 32'(last_load),     32'(tv));
    check({name, ".vtc_viol"},  32'(vtc_viol),      32'd0);
  endtask

  initial begin
    logic [32:0] m;
    logic        found = 1'b0;
    int          nwin, s, l;
    rst       = 1'b1;
    bus.start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst.busy",      32'(bus.busy),            32'd0);
    check("rst.done",      32'(bus.done),            32'd0);
    check("rst.fail",      32'(bus.fail),            32'd0);
    check("rst.load",      32'(bus.delay_load),      32'd0);
    check("rst.en_vtc",    32'(bus.delay_en_vtc),    32'd1);
    check("rst.cnt_value", 32'(bus.delay_cnt_value), 32'd0);
    check("rst.tap_value", 32'(bus.tap_value),       32'd0);
    check("rst.eye_end",   32'(bus.eye_end),         32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    run_cal("single",   range_mask(10, 20), -1, 1'b0);
    run_cal("two_win",  range_mask(3, 6) | range_mask(12, 19), -1, 1'b0);
    run_cal("tie",      range_mask(2, 5) | range_mask(20, 23), -1, 1'b0);
    run_cal("at_max",   range_mask(25, 31), -1, 1'b0);
    run_cal("short",    range_mask(0, 2), -1, 1'b0);
    run_cal("min_eye",  range_mask(4, 7), -1, 1'b0);
    run_cal("glitch",   range_mask(8, 15), 12, 1'b0);
    run_cal("repulse",  range_mask(10, 20), -1, 1'b1);

    // Reset in the middle of sampling tap 9
    clear_monitors();
    pass_mask  = range_mask(10, 20);
    glitch_tap = -1;
    pulse_start();
    for (int i = 0; i < TIMEOUT; i++) begin
      @(negedge clk);
      if (cur_tap == 9 && k == int'(SETTLE_CYCLES) + 3) begin
        found = 1'b1;
        break;
      end
    end
    check("abort.reached_tap9", 32'(found), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("abort.busy",   32'(bus.busy),         32'd0);
    check("abort.en_vtc", 32'(bus.delay_en_vtc), 32'd1);
    check("abort.done",   32'(bus.done),         32'd0);
    check("abort.load",   32'(bus.delay_load),   32'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("abort.no_done", 32'(done_cnt), 32'd0);
    run_cal("after_abort", range_mask(10, 20), -1, 1'b0);

    // Randomised pass sets
    for (int r = 0; r < 4; r++) begin
      m = '0;
      nwin = int'($urandom_range(1, 3));
      for (int w = 0; w < nwin; w++) begin
        s = int'($urandom_range(0, 31));
        l = int'($urandom_range(1, 10));
        for (int b = s; b < s + l && b <= 31; b++) m[b] = 1'b1;
      end
      run_cal($sformatf("rand%0d", r), m, -1, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/idelay_eye_calib.md
Name: idelay_eye_calib

Overview:
- Training controller for the per-lane variable input delay + IDDR capture path. Sweeps the shared delay tap value from 0 to MAX_TAP and checks captured q1/q2 against a known training pattern at each tap.
- Finds the longest contiguous passing window and loads its centre tap.
- Sits between link bring-up logic and the delay/IDDR block; drives its load, cnt_value_in and en_vtc inputs.

Parameters:
- WIDTH, 1, number of data lanes compared (all lanes share one tap value)
- TAP_WIDTH, 9, delay counter width
- MAX_TAP, 511, last tap swept (must be < 2**TAP_WIDTH)
- VTC_WAIT, 16, cycles en_vtc is held low before the first load
- SETTLE_CYCLES, 8, cycles waited after each load before sampling
- SAMPLE_CYCLES, 16, consecutive cycles that must all match for a tap to pass
- MIN_EYE, 4, minimum window length (taps) for success
- DEFAULT_TAP, 0, tap loaded on failure

Ports:
- clk  in  1  clock (same clock as delay/IDDR block)
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle pulse; begins calibration when idle
- sample_q1  in  WIDTH  captured rising-edge data
- sample_q2  in  WIDTH  captured falling-edge data
- pattern_q1  in  WIDTH  expected q1 this cycle
- pattern_q2  in  WIDTH  expected q2 this cycle
- delay_load  out  1  load strobe to delay block
- delay_cnt_value  out  TAP_WIDTH  tap value presented with delay_load
- delay_en_vtc  out  1  VT-compensation enable to delay block
- busy  out  1  calibration in progress
- done  out  1  one-cycle pulse at completion
- fail  out  1  sticky; last calibration found no window >= MIN_EYE
- eye_start  out  TAP_WIDTH  first tap of selected window
- eye_end  out  TAP_WIDTH  last tap of selected window
- tap_value  out  TAP_WIDTH  tap finally loaded

Behaviour:
- Reset values: delay_en_vtc=1, delay_load=0, delay_cnt_value=0, busy=0, done=0, fail=0, eye_start=eye_end=tap_value=0; state IDLE. Reset mid-sweep aborts with the same values on the next edge. No partial results are kept.
- States: IDLE, VTC_OFF, LOAD, SETTLE, SAMPLE, NEXT, APPLY, APPLY_WAIT, FINISH.
- IDLE:
  - start=1 -> VTC_OFF. busy=1, delay_en_vtc=0, fail cleared, tap counter=0, run/best trackers cleared.
  - start while busy is ignored.
- VTC_OFF: wait VTC_WAIT cycles -> LOAD.
- LOAD: delay_load=1 for exactly one cycle with delay_cnt_value=tap -> SETTLE.
- SETTLE: SETTLE_CYCLES cycles; samples ignored -> SAMPLE.
- SAMPLE:
  - SAMPLE_CYCLES cycles. Mismatch = any bit of (sample_q1^pattern_q1)|(sample_q2^pattern_q2).
  - Any mismatch in the window marks the tap as failing; sampling still runs the full count.
- NEXT (1 cycle): update trackers.
  - Pass with no open run: run_start=tap.
  - Fail with an open run: close the run at tap-1.
  - Pass at tap==MAX_TAP: close the run at MAX_TAP.
  - On close, len=end-start+1 (TAP_WIDTH+1 bits). Replace best only if len > best_len (strict), so the earlier window wins ties.
  - Then: tap==MAX_TAP -> APPLY, else tap+1 -> LOAD.
- APPLY:
  - If best_len >= MIN_EYE: tap_value = best_start + ((best_len-1)>>1) (floor centre); eye_start/eye_end = best window; fail=0.
  - Otherwise: tap_value=DEFAULT_TAP, eye_start=eye_end=0, fail=1.
  - Issue one delay_load with delay_cnt_value=tap_value -> APPLY_WAIT.
- APPLY_WAIT: SETTLE_CYCLES cycles -> FINISH.
- FINISH: delay_en_vtc=1, busy=0, done=1 for one cycle -> IDLE.
- delay_load is never asserted while delay_en_vtc=1.
- delay_cnt_value holds its last value between loads.
- Per-tap cost: 1+SETTLE_CYCLES+SAMPLE_CYCLES+1 cycles.

Test Plan:
Bench parameters: MAX_TAP=31, VTC_WAIT=4, SETTLE_CYCLES=2, SAMPLE_CYCLES=4, MIN_EYE=4, DEFAULT_TAP=7, WIDTH=2. The bench model corrupts q1 unless the current loaded tap is in the pass set.
- Pass set [10,20], start pulse -> eye_start=10, eye_end=20, tap_value=15, fail=0, done pulses once. Final delay_load carries 15; delay_en_vtc=0 throughout the sweep.
- Pass sets [3,6]∪[12,19] -> eye 12..19, tap_value=15. Equal windows [2,5]∪[20,23] -> eye 2..5, tap_value=3.
- Pass set [25,31] (window reaching MAX_TAP) -> eye 25..31, tap_value=28. Pass set [0,2] only (len 3) -> fail=1, tap_value=7, eye 0..0.
- Pass set [8,15], but one q2 bit flips in the 3rd sample cycle at tap 12 -> tap 12 fails. Windows 8..11 and 13..15 result -> eye 8..11, tap_value=9.
- Reset asserted during SAMPLE at tap 9 -> next edge: busy=0, delay_en_vtc=1, no done. A new start runs a full clean sweep giving the correct result.
- start re-pulsed while busy -> ignored; exactly 32 LOAD strobes plus 1 APPLY strobe observed.
